// File: rtl/pkt_rx_pkg.sv
// Shared types and helpers for the packet receiver.
// Optional feature macro: PKT_CHECKSUM_EN (adds the trailing XOR checksum byte and CSUM state).
package pkt_rx_pkg;

  typedef enum logic [1:0] {
    PKT_NOP         = 2'd0,
    PKT_UPLOAD      = 2'd1,
    PKT_ENQUEUE     = 2'd2,
    PKT_READ_RESULT = 2'd3
  } pkt_type_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_INSTR = 3'd2,
    ST_DESC  = 3'd3,
    ST_TILE  = 3'd4
`ifdef PKT_CHECKSUM_EN
    , ST_CSUM = 3'd5
`endif
  } rx_state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_TIMEOUT = 2'd1,
    ERR_CSUM    = 2'd2,
    ERR_RSVD    = 2'd3
  } err_code_t;

  // Largest of four sizes; used to dimension shared byte counters.
  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/pkt_shift_assembler.sv
// Byte-in shift register: collects NBYTES bytes MSB first, pulses done on the final byte.
// dat_next is the completed word in the same cycle as done, so the caller can register it.
module pkt_shift_assembler #(
  parameter int NBYTES = 2,
  parameter int CNTW   = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr,
  input  logic                  en,
  input  logic [7:0]            din,
  output logic [8*NBYTES-1:0]   dat_next,
  output logic                  done
);

  logic [CNTW-1:0] cnt;

  assign done = en && (cnt == CNTW'(NBYTES - 1));

  // Byte position within the current word; restarts after each completed word.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= done ? '0 : cnt + CNTW'(1);
    end else begin
      cnt <= cnt;
    end
  end

  if (NBYTES > 1) begin : g_multi
    logic [8*NBYTES-9:0] shreg;

    assign dat_next = {shreg, din};

    // Holds the bytes received so far; the oldest byte ends up in the MSBs.
    always_ff @(posedge clk) begin
      if (reset || clr) begin
        shreg <= '0;
      end else if (en) begin
        shreg <= dat_next[8*NBYTES-9:0];
      end else begin
        shreg <= shreg;
      end
    end
  end else begin : g_single
    assign dat_next = din;
  end

endmodule

// File: rtl/packet_rx_engine.sv
// Byte-stream packet receiver: upload-program, enqueue-program and read-result bursts,
// with mid-packet timeout recovery and error reporting.
// Optional feature macro: PKT_CHECKSUM_EN (trailing XOR byte; final strobes withheld until it matches).
module packet_rx_engine
  import pkt_rx_pkg::*;
#(
  parameter int ADDR_BYTES     = 2,
  parameter int INSTR_BYTES    = 2,
  parameter int DESC_BYTES     = 5,
  parameter int TILE_BYTES     = 36,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      rx_valid,
  input  logic [7:0]                rx_data,
  output logic                      instr_stb,
  output logic [8*ADDR_BYTES-1:0]   instr_addr,
  output logic [8*INSTR_BYTES-1:0]  instr_dat,
  output logic                      enqueue_stb,
  output logic [8*DESC_BYTES-1:0]   enqueue_dat,
  output logic                      tile_stb,
  output logic [8*TILE_BYTES-1:0]   tile_dat,
  output logic [5:0]                tile_idx,
  output logic                      tile_last,
  output logic                      err_stb,
  output logic [1:0]                err_code,
  output logic                      busy
);

  localparam int CNTW = $clog2(max4(TILE_BYTES, DESC_BYTES, ADDR_BYTES, INSTR_BYTES) + 1);
  localparam int TW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam int AW   = 8 * ADDR_BYTES;

  rx_state_t        state_r;
  logic [5:0]       len_r;
  logic [5:0]       word_cnt_r;
  logic [AW-1:0]    addr_r;
  logic [TW-1:0]    idle_cnt_r;

`ifdef PKT_CHECKSUM_EN
  localparam int PW = 8 * max4(TILE_BYTES, DESC_BYTES, 1, 1);
  logic [7:0]       csum_r;
  pkt_type_t        hdr_type_r;
  logic [PW-1:0]    pend_dat_r;
`endif

  logic                      timeout_s;
  logic                      clr_s;
  logic                      addr_en_s, instr_en_s, desc_en_s, tile_en_s;
  logic                      addr_done_s, instr_done_s, desc_done_s, tile_done_s;
  logic [AW-1:0]             addr_next_s;
  logic [8*INSTR_BYTES-1:0]  instr_next_s;
  logic [8*DESC_BYTES-1:0]   desc_next_s;
  logic [8*TILE_BYTES-1:0]   tile_next_s;

  // A byte arriving in the expiry cycle is consumed, so expiry requires a silent cycle.
  assign timeout_s  = (state_r != ST_IDLE) && !rx_valid && (idle_cnt_r == TW'(TIMEOUT_CYCLES - 1));
  assign clr_s      = timeout_s || (state_r == ST_IDLE);
  assign addr_en_s  = rx_valid && (state_r == ST_ADDR);
  assign instr_en_s = rx_valid && (state_r == ST_INSTR);
  assign desc_en_s  = rx_valid && (state_r == ST_DESC);
  assign tile_en_s  = rx_valid && (state_r == ST_TILE);
  assign busy       = (state_r != ST_IDLE);

  pkt_shift_assembler #(.NBYTES(ADDR_BYTES), .CNTW(CNTW)) u_addr (
    .clk(clk), .reset(reset), .clr(clr_s), .en(addr_en_s), .din(rx_data),
    .dat_next(addr_next_s), .done(addr_done_s));

  pkt_shift_assembler #(.NBYTES(INSTR_BYTES), .CNTW(CNTW)) u_instr (
    .clk(clk), .reset(reset), .clr(clr_s), .en(instr_en_s), .din(rx_data),
    .dat_next(instr_next_s), .done(instr_done_s));

  pkt_shift_assembler #(.NBYTES(DESC_BYTES), .CNTW(CNTW)) u_desc (
    .clk(clk), .reset(reset), .clr(clr_s), .en(desc_en_s), .din(rx_data),
    .dat_next(desc_next_s), .done(desc_done_s));

  pkt_shift_assembler #(.NBYTES(TILE_BYTES), .CNTW(CNTW)) u_tile (
    .clk(clk), .reset(reset), .clr(clr_s), .en(tile_en_s), .din(rx_data),
    .dat_next(tile_next_s), .done(tile_done_s));

  // Packet FSM: header decode, payload sequencing, timeout and registered strobes/data.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      len_r       <= '0;
      word_cnt_r  <= '0;
      addr_r      <= '0;
      idle_cnt_r  <= '0;
      instr_stb   <= 1'b0;
      instr_addr  <= '0;
      instr_dat   <= '0;
      enqueue_stb <= 1'b0;
      enqueue_dat <= '0;
      tile_stb    <= 1'b0;
      tile_dat    <= '0;
      tile_idx    <= 6'd0;
      tile_last   <= 1'b0;
      err_stb     <= 1'b0;
      err_code    <= 2'd0;
`ifdef PKT_CHECKSUM_EN
      csum_r      <= 8'd0;
      hdr_type_r  <= PKT_NOP;
      pend_dat_r  <= '0;
`endif
    end else begin
      instr_stb   <= 1'b0;
      enqueue_stb <= 1'b0;
      tile_stb    <= 1'b0;
      err_stb     <= 1'b0;

      if (rx_valid || timeout_s || (state_r == ST_IDLE)) begin
        idle_cnt_r <= '0;
      end else begin
        idle_cnt_r <= idle_cnt_r + TW'(1);
      end

      if (timeout_s) begin
        // Partial words/tiles (and any withheld strobe) are simply abandoned.
        state_r  <= ST_IDLE;
        err_stb  <= 1'b1;
        err_code <= ERR_TIMEOUT;
      end else if (rx_valid) begin
`ifdef PKT_CHECKSUM_EN
        csum_r <= (state_r == ST_IDLE) ? rx_data : (csum_r ^ rx_data);
`endif
        case (state_r)
          ST_IDLE: begin
            len_r      <= rx_data[7:2];
            word_cnt_r <= 6'd0;
`ifdef PKT_CHECKSUM_EN
            hdr_type_r <= pkt_type_t'(rx_data[1:0]);
`endif
            case (pkt_type_t'(rx_data[1:0]))
              PKT_UPLOAD:      state_r <= ST_ADDR;
              PKT_ENQUEUE:     state_r <= ST_DESC;
              PKT_READ_RESULT: state_r <= ST_TILE;
              default:         state_r <= ST_IDLE;
            endcase
          end
          ST_ADDR: begin
            if (addr_done_s) begin
              addr_r  <= addr_next_s;
              state_r <= ST_INSTR;
            end else begin
              state_r <= ST_ADDR;
            end
          end
          ST_INSTR: begin
            if (instr_done_s) begin
              instr_stb  <= 1'b1;
              instr_addr <= addr_r;
              instr_dat  <= instr_next_s;
              addr_r     <= addr_r + AW'(1);
              word_cnt_r <= word_cnt_r + 6'd1;
              if (word_cnt_r == len_r) begin
`ifdef PKT_CHECKSUM_EN
                state_r <= ST_CSUM;
`else
                state_r <= ST_IDLE;
`endif
              end else begin
                state_r <= ST_INSTR;
              end
            end else begin
              state_r <= ST_INSTR;
            end
          end
          ST_DESC: begin
            if (desc_done_s) begin
`ifdef PKT_CHECKSUM_EN
              pend_dat_r <= PW'(desc_next_s);
              state_r    <= ST_CSUM;
`else
              enqueue_stb <= 1'b1;
              enqueue_dat <= desc_next_s;
              state_r     <= ST_IDLE;
`endif
            end else begin
              state_r <= ST_DESC;
            end
          end
          ST_TILE: begin
            if (tile_done_s && (word_cnt_r == len_r)) begin
`ifdef PKT_CHECKSUM_EN
              pend_dat_r <= PW'(tile_next_s);
              state_r    <= ST_CSUM;
`else
              tile_stb  <= 1'b1;
              tile_dat  <= tile_next_s;
              tile_idx  <= word_cnt_r;
              tile_last <= 1'b1;
              state_r   <= ST_IDLE;
`endif
            end else if (tile_done_s) begin
              tile_stb   <= 1'b1;
              tile_dat   <= tile_next_s;
              tile_idx   <= word_cnt_r;
              tile_last  <= 1'b0;
              word_cnt_r <= word_cnt_r + 6'd1;
              state_r    <= ST_TILE;
            end else begin
              state_r <= ST_TILE;
            end
          end
`ifdef PKT_CHECKSUM_EN
          ST_CSUM: begin
            state_r <= ST_IDLE;
            if (rx_data == csum_r) begin
              case (hdr_type_r)
                PKT_ENQUEUE: begin
                  enqueue_stb <= 1'b1;
                  enqueue_dat <= pend_dat_r[8*DESC_BYTES-1:0];
                end
                PKT_READ_RESULT: begin
                  tile_stb  <= 1'b1;
                  tile_dat  <= pend_dat_r[8*TILE_BYTES-1:0];
                  tile_idx  <= len_r;
                  tile_last <= 1'b1;
                end
                default: begin
                  err_stb <= 1'b0;
                end
              endcase
            end else begin
              err_stb  <= 1'b1;
              err_code <= ERR_CSUM;
            end
          end
`endif
          default: state_r <= ST_IDLE;
        endcase
      end else begin
        state_r <= state_r;
      end
    end
  end

endmodule

// File: tb/tb_packet_rx_engine.sv
// Scoreboard bench for packet_rx_engine: a packet-level model pushes expected strobes,
// a monitor pops and compares whenever the DUT strobes.
module tb_packet_rx_engine;

  localparam int T = 40;
`ifdef PKT_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  localparam int K_INSTR = 0;
  localparam int K_ENQ   = 1;
  localparam int K_TILE  = 2;
  localparam int K_ERR   = 3;

  typedef logic [7:0] bq_t [$];

  typedef struct {
    int           kind;
    logic [287:0] dat;
    logic [15:0]  addr;
    int           idx;
    int           last;
    int           code;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         rx_valid;
  logic [7:0]   rx_data;
  logic         instr_stb;
  logic [15:0]  instr_addr;
  logic [15:0]  instr_dat;
  logic         enqueue_stb;
  logic [39:0]  enqueue_dat;
  logic         tile_stb;
  logic [287:0] tile_dat;
  logic [5:0]   tile_idx;
  logic         tile_last;
  logic         err_stb;
  logic [1:0]   err_code;
  logic         busy;

  exp_t exp_q [$];
  int   errors = 0;
  int   checks = 0;

  packet_rx_engine #(
    .ADDR_BYTES(2), .INSTR_BYTES(2), .DESC_BYTES(5), .TILE_BYTES(36), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .instr_stb(instr_stb), .instr_addr(instr_addr), .instr_dat(instr_dat),
    .enqueue_stb(enqueue_stb), .enqueue_dat(enqueue_dat),
    .tile_stb(tile_stb), .tile_dat(tile_dat), .tile_idx(tile_idx), .tile_last(tile_last),
    .err_stb(err_stb), .err_code(err_code), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [287:0] act, input logic [287:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push(input int kind, input logic [287:0] dat, input logic [15:0] addr,
                      input int idx, input int last, input int code);
    exp_t e;
    e.kind = kind; e.dat = dat; e.addr = addr; e.idx = idx; e.last = last; e.code = code;
    exp_q.push_back(e);
  endtask

  // Payload length implied by a header, excluding header and checksum.
  function automatic int payload_len(input int typ, input int l);
    case (typ)
      1:       return 2 + 2 * (l + 1);
      2:       return 5;
      3:       return 36 * (l + 1);
      default: return 0;
    endcase
  endfunction

  function automatic bq_t with_csum(input bq_t p);
    bq_t q;
    logic [7:0] x;
    q = p;
    x = 8'd0;
    foreach (p[i]) x = x ^ p[i];
    if (CSUM_EN && (p[0][1:0] != 2'd0)) q.push_back(x);
    return q;
  endfunction

  // Expected strobes when the first n bytes of packet p are delivered.
  task automatic model(input bq_t p, input int n);
    int typ, l, plen, full_n;
    bit full, ok;
    logic [7:0] x;
    logic [15:0] a;
    logic [287:0] d;
    typ = int'(p[0][1:0]);
    l = int'(p[0][7:2]);
    plen = payload_len(typ, l);
    full_n = 1 + plen + ((CSUM_EN && typ != 0) ? 1 : 0);
    full = (n >= full_n);
    x = 8'd0;
    for (int i = 0; i <= plen; i++) x = x ^ p[i];
    ok = full && (!CSUM_EN || typ == 0 || p[plen + 1] == x);
    if (typ == 1) begin
      a = {p[1], p[2]};
      for (int i = 0; i <= l; i++)
        if (n >= 3 + 2 * (i + 1))
          push(K_INSTR, 288'({p[3 + 2 * i], p[4 + 2 * i]}), a + 16'(i), 0, 0, 0);
    end else if (typ == 2) begin
      if (ok) push(K_ENQ, 288'({p[1], p[2], p[3], p[4], p[5]}), 16'd0, 0, 0, 0);
    end else if (typ == 3) begin
      for (int i = 0; i <= l; i++) begin
        if (n >= 1 + 36 * (i + 1) && (i < l || ok)) begin
          d = '0;
          for (int j = 0; j < 36; j++) d = {d[279:0], p[1 + 36 * i + j]};
          push(K_TILE, d, 16'd0, i, (i == l) ? 1 : 0, 0);
        end
      end
    end
    if (typ != 0) begin
      if (!full) push(K_ERR, '0, 16'd0, 0, 0, 1);
      else if (!ok) push(K_ERR, '0, 16'd0, 0, 0, 2);
    end
  endtask

  task automatic gap(input int g);
    repeat (g) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  function automatic int pick_gap();
    int r;
    r = int'($urandom_range(0, 19));
    return (r == 0) ? (T - 1) : (r % 3);
  endfunction

  // Model then deliver n bytes; a truncated packet is followed by exactly T silent cycles.
  task automatic send_pkt(input bq_t p, input int n, input bit rand_gaps);
    model(p, n);
    for (int i = 0; i < n; i++) begin
      send_byte(p[i]);
      if (rand_gaps && i < n - 1) gap(pick_gap());
    end
    if (n < p.size()) gap(T);
  endtask

  function automatic bq_t rand_pkt();
    bq_t p;
    int typ, l;
    typ = int'($urandom_range(0, 3));
    case (typ)
      1:       l = int'($urandom_range(0, 3));
      3:       l = int'($urandom_range(0, 2));
      default: l = int'($urandom_range(0, 63));
    endcase
    p.push_back({6'(l), 2'(typ)});
    for (int i = 0; i < payload_len(typ, l); i++) p.push_back(8'($urandom));
    return with_csum(p);
  endfunction

  // Monitor: every DUT strobe pops one expectation and is compared field by field.
  exp_t mon_e;
  int   mon_n;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      mon_n = int'(instr_stb) + int'(enqueue_stb) + int'(tile_stb) + int'(err_stb);
      if (mon_n != 0) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_strobe actual instr=%0d enq=%0d tile=%0d err=%0d required none",
                   instr_stb, enqueue_stb, tile_stb, err_stb);
        end else begin
          mon_e = exp_q.pop_front();
          chk("strobe_count", 288'(mon_n), 288'(1));
          case (mon_e.kind)
            K_INSTR: begin
              chk("instr_stb", 288'(instr_stb), 288'(1));
              chk("instr_addr", 288'(instr_addr), 288'(mon_e.addr));
              chk("instr_dat", 288'(instr_dat), mon_e.dat);
            end
            K_ENQ: begin
              chk("enqueue_stb", 288'(enqueue_stb), 288'(1));
              chk("enqueue_dat", 288'(enqueue_dat), mon_e.dat);
            end
            K_TILE: begin
              chk("tile_stb", 288'(tile_stb), 288'(1));
              chk("tile_dat", tile_dat, mon_e.dat);
              chk("tile_idx", 288'(tile_idx), 288'(mon_e.idx));
              chk("tile_last", 288'(tile_last), 288'(mon_e.last));
            end
            default: begin
              chk("err_stb", 288'(err_stb), 288'(1));
              chk("err_code", 288'(err_code), 288'(mon_e.code));
            end
          endcase
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bq_t p;
    int n;
    reset = 1'b1;
    rx_valid = 1'b0;
    rx_data = 8'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_busy", 288'(busy), 288'(0));
    chk("rst_instr_stb", 288'(instr_stb), 288'(0));
    chk("rst_tile_stb", 288'(tile_stb), 288'(0));
    chk("rst_err_stb", 288'(err_stb), 288'(0));
    chk("rst_err_code", 288'(err_code), 288'(0));
    chk("rst_tile_dat", tile_dat, 288'(0));

    // Upload example, then idle
    p = with_csum('{8'h05, 8'h00, 8'h10, 8'hAA, 8'hBB, 8'hCC, 8'hDD});
    send_pkt(p, p.size(), 1'b0);
    chk("busy_after_upload", 288'(busy), 288'(0));
    gap(2);

    // Address wrap
    p = with_csum('{8'h05, 8'hFF, 8'hFF, 8'h12, 8'h34, 8'h56, 8'h78});
    send_pkt(p, p.size(), 1'b1);
    gap(2);

    // Enqueue with one-cycle strobe latency
    p = with_csum('{8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05});
    send_pkt(p, p.size(), 1'b0);
    chk("enq_latency", 288'(enqueue_stb), 288'(1));
    gap(2);

    // Two-tile burst, followed back-to-back by a no-op and an enqueue
    p = '{8'h07};
    for (int i = 0; i < 72; i++) p.push_back(8'(i + 1));
    p = with_csum(p);
    send_pkt(p, p.size(), 1'b0);
    send_pkt('{8'hFC}, 1, 1'b0);
    p = with_csum('{8'hFE, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55});
    send_pkt(p, p.size(), 1'b0);
    gap(3);

    // Timeout mid-tile, then a normal packet
    p = '{8'h03};
    for (int i = 0; i < 36; i++) p.push_back(8'($urandom));
    p = with_csum(p);
    send_pkt(p, 11, 1'b0);
    chk("busy_after_timeout", 288'(busy), 288'(0));
    p = with_csum('{8'h02, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5});
    send_pkt(p, p.size(), 1'b1);
    gap(2);

    // Reset mid-tile: nothing expected
    for (int i = 0; i < 21; i++) send_byte((i == 0) ? 8'h03 : 8'(i));
    chk("busy_mid_tile", 288'(busy), 288'(1));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("busy_after_reset", 288'(busy), 288'(0));
    gap(T + 5);

`ifdef PKT_CHECKSUM_EN
    p = with_csum('{8'h02, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50});
    send_pkt(p, p.size(), 1'b0);
    gap(2);
    p = with_csum('{8'h02, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50});
    p[3] = p[3] ^ 8'h01;
    send_pkt(p, p.size(), 1'b0);
    gap(2);
`endif

    // Randomized traffic with occasional truncation and checksum corruption
    for (int k = 0; k < 60; k++) begin
      p = rand_pkt();
      if (CSUM_EN && p.size() > 1 && $urandom_range(0, 5) == 0)
        p[p.size() - 1] = p[p.size() - 1] ^ 8'h5A;
      n = p.size();
      if (p.size() > 1 && $urandom_range(0, 7) == 0) n = int'($urandom_range(1, p.size() - 1));
      send_pkt(p, n, 1'b1);
      gap(int'($urandom_range(0, 3)));
    end

    gap(T + 5);
    chk("scoreboard_drained", 288'(exp_q.size()), 288'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
